// File: rtl/vram_arbiter.sv
// Shares the single-port work/video RAM between the i8080 bus and the video fetcher.
// Video wins by default; a streak counter forces one CPU slot after STARVE_MAX video grants.
module vram_arbiter #(
   parameter int ADDR_W     = 13,
   parameter int DATA_W     = 8,
   parameter int STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_gnt,
   output logic              vid_rvalid,
   output logic [DATA_W-1:0] vid_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_CPU  = 2'd1;
   localparam logic [1:0] OWN_VID  = 2'd2;

   localparam logic [3:0] STREAK_LIM = 4'(STARVE_MAX);

   logic [3:0] streak_q, streak_d;
   logic [1:0] rd_owner_q, rd_owner_d;
   logic       gnt_cpu, gnt_vid;

   // Grants are gated by reset so nothing reaches the RAM while rst is low,
   // including a grant that was in flight when reset asserted mid-cycle.
   always_comb begin
      gnt_vid = 1'b0;
      gnt_cpu = 1'b0;
      if (rst) begin
         if (vid_req && (!cpu_req || (streak_q < STREAK_LIM))) begin
            gnt_vid = 1'b1;
         end else if (cpu_req) begin
            gnt_cpu = 1'b1;
         end
      end
   end

   always_comb begin
      streak_d = streak_q;
      if (!cpu_req || gnt_cpu) begin
         streak_d = 4'd0;
      end else if (gnt_vid && (streak_q < STREAK_LIM)) begin
         streak_d = streak_q + 4'd1;
      end
   end

   always_comb begin
      rd_owner_d = OWN_NONE;
      if (gnt_cpu && !cpu_we) begin
         rd_owner_d = OWN_CPU;
      end else if (gnt_vid) begin
         rd_owner_d = OWN_VID;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         streak_q   <= 4'd0;
         rd_owner_q <= OWN_NONE;
      end else begin
         streak_q   <= streak_d;
         rd_owner_q <= rd_owner_d;
      end
   end

   always_comb begin
      cpu_gnt   = gnt_cpu;
      vid_gnt   = gnt_vid;
      mem_en    = gnt_cpu | gnt_vid;
      mem_we    = gnt_cpu & cpu_we;
      mem_wdata = gnt_cpu ? cpu_wdata : '0;
      mem_addr  = '0;
      if (gnt_cpu) begin
         mem_addr = cpu_addr;
      end else if (gnt_vid) begin
         mem_addr = vid_addr;
      end
   end

   // Read data is a combinational pass-through, zeroed when not owned.
   always_comb begin
      cpu_rvalid = (rd_owner_q == OWN_CPU);
      vid_rvalid = (rd_owner_q == OWN_VID);
      cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
      vid_rdata  = vid_rvalid ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural RAM, per-cycle grant expectations,
// and read-data queues filled from a reference copy of the RAM contents.
module tb_vram_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we;
   logic [12:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_gnt, cpu_rvalid;
   logic [7:0]  cpu_rdata;
   logic        vid_req;
   logic [12:0] vid_addr;
   logic        vid_gnt, vid_rvalid;
   logic [7:0]  vid_rdata;
   logic        mem_en, mem_we;
   logic [12:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;

   int n_chk  = 0;
   int n_pass = 0;

   logic [7:0] exp_cpu_q[$];
   logic [7:0] exp_vid_q[$];
   logic       cpu_rv_pend = 1'b0;
   logic       vid_rv_pend = 1'b0;

   logic [7:0] ref_mem [0:8191] = '{default: 8'h00};
   logic [7:0] ram     [0:8191] = '{default: 8'h00};

   always #5 clk = ~clk;

   vram_arbiter #(.ADDR_W(13), .DATA_W(8), .STARVE_MAX(4)) dut (
      .clk        (clk),
      .rst        (rst_n),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .vid_req    (vid_req),
      .vid_addr   (vid_addr),
      .vid_gnt    (vid_gnt),
      .vid_rvalid (vid_rvalid),
      .vid_rdata  (vid_rdata),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   // Synchronous single-port RAM, one-cycle read latency.
   always @(posedge clk) begin
      if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   // Read-return checks shared by every cycle.
   task automatic check_returns();
      logic [7:0] e;
      check_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(cpu_rv_pend));
      check_eq("vid_rvalid", 32'(vid_rvalid), 32'(vid_rv_pend));
      if (cpu_rvalid) begin
         if (exp_cpu_q.size() == 0) begin
            check_eq("cpu_rdata_unexpected", 32'(cpu_rvalid), 32'd0);
         end else begin
            e = exp_cpu_q.pop_front();
            check_eq("cpu_rdata", 32'(cpu_rdata), 32'(e));
         end
      end else begin
         check_eq("cpu_rdata_idle", 32'(cpu_rdata), 32'd0);
      end
      if (vid_rvalid) begin
         if (exp_vid_q.size() == 0) begin
            check_eq("vid_rdata_unexpected", 32'(vid_rvalid), 32'd0);
         end else begin
            e = exp_vid_q.pop_front();
            check_eq("vid_rdata", 32'(vid_rdata), 32'(e));
         end
      end else begin
         check_eq("vid_rdata_idle", 32'(vid_rdata), 32'd0);
      end
   endtask

   // One clock cycle: drive at posedge+1, check at negedge, update the model.
   task automatic step(input logic c_req, input logic c_we, input logic [12:0] c_addr,
                       input logic [7:0] c_wd, input logic v_req, input logic [12:0] v_addr,
                       input logic e_c, input logic e_v);
      logic [12:0] e_addr;
      cpu_req   = c_req;
      cpu_we    = c_we;
      cpu_addr  = c_addr;
      cpu_wdata = c_wd;
      vid_req   = v_req;
      vid_addr  = v_addr;
      @(negedge clk);
      e_addr = e_c ? c_addr : (e_v ? v_addr : 13'd0);
      check_eq("cpu_gnt", 32'(cpu_gnt), 32'(e_c));
      check_eq("vid_gnt", 32'(vid_gnt), 32'(e_v));
      check_eq("mem_en", 32'(mem_en), 32'(e_c | e_v));
      check_eq("mem_we", 32'(mem_we), 32'(e_c & c_we));
      check_eq("mem_addr", 32'(mem_addr), 32'(e_addr));
      check_eq("mem_wdata", 32'(mem_wdata), e_c ? 32'(c_wd) : 32'd0);
      check_returns();
      cpu_rv_pend = e_c && !c_we;
      vid_rv_pend = e_v;
      if (e_c && !c_we) exp_cpu_q.push_back(ref_mem[c_addr]);
      if (e_c && c_we) ref_mem[c_addr] = c_wd;
      if (e_v) exp_vid_q.push_back(ref_mem[v_addr]);
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 13'd0, 8'd0, 1'b0, 13'd0, 1'b0, 1'b0);
   endtask

   // Reset asserted mid-cycle with requests left as they were; all outputs must drop.
   task automatic reset_cycle();
      rst_n = 1'b0;
      @(negedge clk);
      check_eq("rst_cpu_gnt", 32'(cpu_gnt), 32'd0);
      check_eq("rst_vid_gnt", 32'(vid_gnt), 32'd0);
      check_eq("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
      check_eq("rst_vid_rvalid", 32'(vid_rvalid), 32'd0);
      check_eq("rst_mem_en", 32'(mem_en), 32'd0);
      check_eq("rst_mem_we", 32'(mem_we), 32'd0);
      check_eq("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
      check_eq("rst_vid_rdata", 32'(vid_rdata), 32'd0);
      exp_cpu_q.delete();
      exp_vid_q.delete();
      cpu_rv_pend = 1'b0;
      vid_rv_pend = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = 13'h0010;
      cpu_wdata = 8'h00;
      vid_req   = 1'b1;
      vid_addr  = 13'h0020;
      @(posedge clk);
      #1;
      reset_cycle();

      // CPU write then read back
      step(1'b1, 1'b1, 13'h0400, 8'h3C, 1'b0, 13'd0, 1'b1, 1'b0);
      step(1'b1, 1'b0, 13'h0400, 8'h00, 1'b0, 13'd0, 1'b1, 1'b0);
      idle();

      // Fill 0..7 for the video scan, then back-to-back video reads
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b1, 13'(i), 8'(8'hA0 + i), 1'b0, 13'd0, 1'b1, 1'b0);
      end
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 13'd0, 8'd0, 1'b1, 13'(i), 1'b0, 1'b1);
      end
      idle();

      // Both continuously requesting: V,V,V,V,C repeating
      for (int k = 0; k < 15; k++) begin
         step(1'b1, 1'b0, 13'h0400, 8'd0, 1'b1, 13'(k % 8), (k % 5) == 4, (k % 5) != 4);
      end
      idle();

      // CPU arrives after 10 video-only grants; streak counts from the first overlap
      for (int k = 0; k < 10; k++) begin
         step(1'b0, 1'b0, 13'd0, 8'd0, 1'b1, 13'(k), 1'b0, 1'b1);
      end
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 1'b0, 13'h0400, 8'd0, 1'b1, 13'(10 + k), k == 4, k != 4);
      end
      idle();

      // Same-address collision: video reads old value, CPU write lands next
      step(1'b1, 1'b1, 13'h0100, 8'h11, 1'b0, 13'd0, 1'b1, 1'b0);
      idle();
      step(1'b1, 1'b1, 13'h0100, 8'h22, 1'b1, 13'h0100, 1'b0, 1'b1);
      step(1'b1, 1'b1, 13'h0100, 8'h22, 1'b0, 13'd0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 13'd0, 8'd0, 1'b1, 13'h0100, 1'b0, 1'b1);
      idle();

      // Reset with streak at 3 and a video read in flight; streak must restart
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, 13'h0400, 8'd0, 1'b1, 13'(k), 1'b0, 1'b1);
      end
      reset_cycle();
      for (int k = 0; k < 5; k++) begin
         step(1'b1, 1'b0, 13'h0400, 8'd0, 1'b1, 13'(k), k == 4, k != 4);
      end
      idle();

      // Reset the cycle after a CPU read grant; pending CPU is granted on release
      step(1'b1, 1'b0, 13'h0400, 8'd0, 1'b0, 13'd0, 1'b1, 1'b0);
      reset_cycle();
      step(1'b1, 1'b0, 13'h0400, 8'd0, 1'b0, 13'd0, 1'b1, 1'b0);
      idle();
      idle();

      check_eq("cpu_queue_drained", 32'(exp_cpu_q.size()), 32'd0);
      check_eq("vid_queue_drained", 32'(exp_vid_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Two-port arbiter that shares the single-port synchronous work/video RAM (8 KiB, CPU window 0x2000-0x3FFF) between the i8080 bus and the video scanout fetcher.
- Video has fixed priority. A starvation guard guarantees the CPU one slot after STARVE_MAX consecutive video grants taken while the CPU was waiting.
- Sits between the CPU bus decode, the video fetch unit and the RAM macro.

Parameters:
- ADDR_W, 13, RAM word address width (8 KiB).
- DATA_W, 8, data width.
- STARVE_MAX, 4, consecutive video grants allowed while cpu_req is pending before the CPU is forced in; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req  in  1  CPU access request; held with stable addr/we/wdata until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU word address (already offset by 0x2000).
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  one-cycle pulse: request accepted this cycle; also the CPU wait-state release.
- cpu_rvalid  out  1  pulses the cycle after a CPU read grant.
- cpu_rdata  out  DATA_W  read data, valid when cpu_rvalid.
- vid_req  in  1  video read request; held until vid_gnt.
- vid_addr  in  ADDR_W  video read address.
- vid_gnt  out  1  one-cycle pulse: video request accepted.
- vid_rvalid  out  1  pulses the cycle after a video grant.
- vid_rdata  out  DATA_W  video read data, valid when vid_rvalid.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, one cycle after mem_en with mem_we=0.

Behaviour:
- Grant decision is combinational from req, streak and the registered state, within the same cycle N.
  - mem_* drive the granted request in cycle N; the RAM samples at the end of N.
  - gnt pulses in N. A requester may present a new request in N+1, so back-to-back grants are allowed.
- Read return:
  - The owner of each grant is registered (rd_owner: NONE/CPU/VID).
  - In N+1 the matching rvalid is 1 and rdata = mem_rdata, passed through combinationally.
  - Writes produce no rvalid.
- Arbitration each cycle:
  - Neither req: no grant, mem_en=0, mem_we=0.
  - Only one req: grant it.
  - Both req and streak < STARVE_MAX: grant video.
  - Both req and streak == STARVE_MAX: grant CPU.
- streak counter (4 bits):
  - Increments on a video grant while cpu_req=1.
  - Clears on a CPU grant, or in any cycle with cpu_req=0.
  - Saturates at STARVE_MAX.
- mem_wdata = cpu_wdata when the CPU is granted, else 0. mem_we = cpu_we only on a CPU grant.
- Idle cycles drive mem_addr = 0.
- Outputs are stable every cycle; no output toggles without a req.
- Reset (rst=0, asynchronous):
  - streak=0, rd_owner=NONE.
  - All gnt/rvalid/mem_en/mem_we = 0, rdata = 0.
  - A read granted in the cycle reset asserts produces no rvalid after reset releases.
  - Reset release is sampled synchronously; the first grant is possible in the first cycle with rst=1.
- Addresses are not range-checked; decode is upstream.

Test Plan:
- CPU-only write 0x3C to addr 0x0400, then read 0x0400 -> cpu_gnt in each request cycle, mem_we=1 on the write; cpu_rvalid one cycle after the read grant with cpu_rdata=0x3C; vid_* stay 0.
- Video-only reads 0x0000..0x0007 back-to-back with vid_req held high -> vid_gnt 8 consecutive cycles; vid_rvalid 8 consecutive cycles, each lagging its grant by 1, with the data written earlier by the CPU.
- vid_req and cpu_req both continuously high, STARVE_MAX=4 -> grant pattern V,V,V,V,C repeating; cpu_gnt exactly every 5th cycle; streak never exceeds 4.
- cpu_req rises one cycle after vid_req has been granted 10 times -> streak starts counting from the first overlapping grant; CPU is granted after 4 overlapping video grants, not earlier.
- Simultaneous CPU write and video read to the same addr 0x0100 (old 0x11, new 0x22) with streak=0 -> video granted first and returns 0x11; CPU write is granted next cycle; the following video read returns 0x22.
- Assert rst=0 mid-stream in the cycle after a CPU read grant -> cpu_rvalid drops immediately, streak=0; after release, the first pending request is granted in the first rst=1 cycle.
